// File: rtl/iceboard_rx_conditioner.sv
// ---------------------------------------------------------------------------
// iceboard_rx_conditioner
//
// Pin-side front end for the iceboardcontrol UART receive lines. Each
// asynchronous rx pin is synchronised, deglitched by a run-length filter,
// watched for a stuck-low condition (break or unplugged board), and its
// rejected glitches are counted for diagnostics.
//
// Ports:
//   clk         system clock (clk_clk domain)
//   reset_n     synchronous reset, active low
//   rx_pin      raw asynchronous rx pins, idle high, one per channel
//   rx_out      conditioned rx towards soc_system iceboardcontrol_N rx
//   break_det   per channel, 1 while the filtered line has been low for at
//               least BREAK_CYCLES cycles
//   glitch_cnt  saturating glitch counters, channel 0 in [CNT_W-1:0]
//   clear_cnt   single-cycle pulse that zeroes every glitch counter
//
// Configuration macro:
//   BREAK_MASK_EN  when defined, rx_out is held at 1 while break_det is set
//                  so the downstream UART sees idle instead of a stream of
//                  framing errors. Without it rx_out always follows the
//                  filtered level and break_det is status only.
// ---------------------------------------------------------------------------
module iceboard_rx_conditioner #(
  parameter int NUM_CH       = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int BREAK_CYCLES = 50000,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       rx_pin,
  output logic [NUM_CH-1:0]       rx_out,
  output logic [NUM_CH-1:0]       break_det,
  output logic [NUM_CH*CNT_W-1:0] glitch_cnt,
  input  logic                    clear_cnt
);

  localparam int RUN_W = $clog2(FILTER_LEN);
  localparam int BRK_W = $clog2(BREAK_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(FILTER_LEN - 1);
  localparam logic [BRK_W-1:0] BRK_LIMIT = BRK_W'(BREAK_CYCLES);

  typedef enum logic [1:0] {
    BRK_IDLE,
    BRK_LOW,
    BRK_BREAK
  } brk_state_e;

  logic [SYNC_STAGES-1:0] sync_q  [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d  [NUM_CH];
  logic [RUN_W-1:0]       run_q   [NUM_CH];
  logic [RUN_W-1:0]       run_d   [NUM_CH];
  logic [CNT_W-1:0]       gcnt_q  [NUM_CH];
  logic [CNT_W-1:0]       gcnt_d  [NUM_CH];
  logic [BRK_W-1:0]       bcnt_q  [NUM_CH];
  logic [BRK_W-1:0]       bcnt_d  [NUM_CH];
  brk_state_e             state_q [NUM_CH];
  brk_state_e             state_d [NUM_CH];
  logic [NUM_CH-1:0]      filt_q;
  logic [NUM_CH-1:0]      filt_d;
  logic [NUM_CH-1:0]      break_q;
  logic [NUM_CH-1:0]      break_d;
  logic [NUM_CH-1:0]      glitch;

  // Synchroniser shift, run-length filter and glitch counters.
  // The filter only looks at the last synchroniser stage; a level change is
  // accepted on the FILTER_LEN-th consecutive mismatching sample, and a
  // mismatch run that ends early is a glitch.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], rx_pin[ch]};
      filt_d[ch] = filt_q[ch];
      run_d[ch]  = run_q[ch];
      glitch[ch] = 1'b0;

      if (sync_q[ch][SYNC_STAGES-1] != filt_q[ch]) begin
        if (run_q[ch] == RUN_LAST) begin
          filt_d[ch] = sync_q[ch][SYNC_STAGES-1];
          run_d[ch]  = '0;
        end else begin
          run_d[ch] = run_q[ch] + RUN_W'(1);
        end
      end else if (run_q[ch] != '0) begin
        run_d[ch]  = '0;
        glitch[ch] = 1'b1;
      end

      // Clear has priority over a same-cycle increment; saturate, never wrap.
      gcnt_d[ch] = gcnt_q[ch];
      if (clear_cnt) begin
        gcnt_d[ch] = '0;
      end else if (glitch[ch] && (gcnt_q[ch] != '1)) begin
        gcnt_d[ch] = gcnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Break detector, one FSM per channel, driven by the filtered level.
  // Transitions use filt_d so that the counter reads 1 in the first
  // filtered-low cycle and break_det drops in the same cycle the filtered
  // level returns high.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch] = state_q[ch];
      bcnt_d[ch]  = bcnt_q[ch];
      break_d[ch] = break_q[ch];

      case (state_q[ch])
        BRK_IDLE: begin
          if (!filt_d[ch]) begin
            bcnt_d[ch] = BRK_W'(1);
            if (BRK_LIMIT == BRK_W'(1)) begin
              state_d[ch] = BRK_BREAK;
              break_d[ch] = 1'b1;
            end else begin
              state_d[ch] = BRK_LOW;
            end
          end
        end
        BRK_LOW: begin
          if (filt_d[ch]) begin
            state_d[ch] = BRK_IDLE;
            bcnt_d[ch]  = '0;
          end else begin
            bcnt_d[ch] = bcnt_q[ch] + BRK_W'(1);
            if ((bcnt_q[ch] + BRK_W'(1)) == BRK_LIMIT) begin
              state_d[ch] = BRK_BREAK;
              break_d[ch] = 1'b1;
            end
          end
        end
        BRK_BREAK: begin
          if (filt_d[ch]) begin
            state_d[ch] = BRK_IDLE;
            bcnt_d[ch]  = '0;
            break_d[ch] = 1'b0;
          end
        end
        default: begin
          state_d[ch] = BRK_IDLE;
          bcnt_d[ch]  = '0;
          break_d[ch] = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset returns every channel to an idle-high line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q  <= '1;
      break_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch]  <= '1;
        run_q[ch]   <= '0;
        gcnt_q[ch]  <= '0;
        bcnt_q[ch]  <= '0;
        state_q[ch] <= BRK_IDLE;
      end
    end else begin
      filt_q  <= filt_d;
      break_q <= break_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch]  <= sync_d[ch];
        run_q[ch]   <= run_d[ch];
        gcnt_q[ch]  <= gcnt_d[ch];
        bcnt_q[ch]  <= bcnt_d[ch];
        state_q[ch] <= state_d[ch];
      end
    end
  end

  // Outputs are built only from registers.
`ifdef BREAK_MASK_EN
  assign rx_out = filt_q | break_q;
`else
  assign rx_out = filt_q;
`endif

  assign break_det = break_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign glitch_cnt[g*CNT_W +: CNT_W] = gcnt_q[g];
  end

endmodule

// File: tb/tb_iceboard_rx_conditioner.sv
// ---------------------------------------------------------------------------
// tb_iceboard_rx_conditioner
//
// Self-checking bench for iceboard_rx_conditioner (3 channels, 2 sync
// stages, filter length 4, break after 100 cycles, 4-bit glitch counters).
// A behavioural model predicts the outputs after every clock edge and
// queues them; a negedge monitor pops and compares. Directed checks cover
// reset, edge latency, glitch counting, saturation/clear, break detection
// and a reset issued in the middle of a break.
// ---------------------------------------------------------------------------
module tb_iceboard_rx_conditioner;

  localparam int NUM_CH       = 3;
  localparam int SYNC_STAGES  = 2;
  localparam int FILTER_LEN   = 4;
  localparam int BREAK_CYCLES = 100;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef BREAK_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       rx_pin;
  logic                    clear_cnt;
  logic [NUM_CH-1:0]       rx_out;
  logic [NUM_CH-1:0]       break_det;
  logic [NUM_CH*CNT_W-1:0] glitch_cnt;

  iceboard_rx_conditioner #(
    .NUM_CH       (NUM_CH),
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_LEN   (FILTER_LEN),
    .BREAK_CYCLES (BREAK_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_pin     (rx_pin),
    .rx_out     (rx_out),
    .break_det  (break_det),
    .glitch_cnt (glitch_cnt),
    .clear_cnt  (clear_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0]       rx;
    logic [NUM_CH-1:0]       brk;
    logic [NUM_CH*CNT_W-1:0] gc;
  } expect_t;

  expect_t scoreboard[$];
  expect_t monExp;

  int checkCount = 0;
  int passCount  = 0;

  // Model state
  logic mSync0 [NUM_CH];
  logic mSync1 [NUM_CH];
  logic mFilt  [NUM_CH];
  int   mRun   [NUM_CH];
  int   mGc    [NUM_CH];
  int   mLow   [NUM_CH];

  // Channel 0 event tracker
  int   tickNo = 0;
  logic prevRx0 = 1'b1;
  logic prevBrk0 = 1'b0;
  int   fallTick, riseBrkTick, fallBrkTick;
  logic rxAtBrkRise, rxAtBrkFall, rxBeforeBrkFall;
  logic [NUM_CH-1:0] seenLow;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Behavioural prediction of the outputs after one clock edge.
  task automatic modelStep(input logic [NUM_CH-1:0] pin, input logic clr,
                           input logic rstN);
    expect_t e;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic s;
      logic isGlitch;
      if (!rstN) begin
        mSync0[ch] = 1'b1;
        mSync1[ch] = 1'b1;
        mFilt[ch]  = 1'b1;
        mRun[ch]   = 0;
        mGc[ch]    = 0;
        mLow[ch]   = 0;
      end else begin
        s        = mSync1[ch];
        isGlitch = 1'b0;
        if (s !== mFilt[ch]) begin
          mRun[ch]++;
          if (mRun[ch] == FILTER_LEN) begin
            mFilt[ch] = s;
            mRun[ch]  = 0;
          end
        end else if (mRun[ch] > 0) begin
          isGlitch = 1'b1;
          mRun[ch] = 0;
        end
        if (mFilt[ch] == 1'b0) begin
          if (mLow[ch] < BREAK_CYCLES) mLow[ch]++;
        end else begin
          mLow[ch] = 0;
        end
        if (clr) mGc[ch] = 0;
        else if (isGlitch && mGc[ch] < CNT_MAX) mGc[ch]++;
        mSync1[ch] = mSync0[ch];
        mSync0[ch] = pin[ch];
      end
      e.brk[ch] = (mFilt[ch] == 1'b0) && (mLow[ch] >= BREAK_CYCLES);
      e.rx[ch]  = mFilt[ch] | (MASKED & e.brk[ch]);
      e.gc[ch*CNT_W +: CNT_W] = mGc[ch][CNT_W-1:0];
    end
    scoreboard.push_back(e);
  endtask

  // Drive one clock cycle of stimulus, predict, then note channel 0 events.
  task automatic applyStimulus(input logic [NUM_CH-1:0] pin, input logic clr,
                               input logic rstN);
    rx_pin    = pin;
    clear_cnt = clr;
    reset_n   = rstN;
    @(posedge clk);
    modelStep(pin, clr, rstN);
    #1;
    tickNo++;
    if (prevRx0 && !rx_out[0] && fallTick < 0) fallTick = tickNo;
    if (!prevBrk0 && break_det[0] && riseBrkTick < 0) begin
      riseBrkTick = tickNo;
      rxAtBrkRise = rx_out[0];
    end
    if (prevBrk0 && !break_det[0] && fallBrkTick < 0) begin
      fallBrkTick     = tickNo;
      rxAtBrkFall     = rx_out[0];
      rxBeforeBrkFall = prevRx0;
    end
    seenLow  = seenLow | ~rx_out;
    prevRx0  = rx_out[0];
    prevBrk0 = break_det[0];
  endtask

  task automatic applyFor(input logic [NUM_CH-1:0] pin, input int n);
    for (int i = 0; i < n; i++) applyStimulus(pin, 1'b0, 1'b1);
  endtask

  task automatic resetTracker();
    fallTick    = -1;
    riseBrkTick = -1;
    fallBrkTick = -1;
  endtask

  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      monExp = scoreboard.pop_front();
      checkOutput("sb_rx_out", 32'(rx_out), 32'(monExp.rx));
      checkOutput("sb_break_det", 32'(break_det), 32'(monExp.brk));
      checkOutput("sb_glitch_cnt", 32'(glitch_cnt), 32'(monExp.gc));
    end
  end

  initial begin
    int lat;
    int guard;
    reset_n   = 1'b0;
    rx_pin    = '0;
    clear_cnt = 1'b0;
    seenLow   = '0;
    resetTracker();

    // 1. Reset held with pins low
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b000, 1'b0, 1'b0);
      checkOutput("reset_rx_out", 32'(rx_out), 32'h7);
      checkOutput("reset_break_det", 32'(break_det), 32'h0);
      checkOutput("reset_glitch_cnt", 32'(glitch_cnt), 32'h0);
    end
    applyStimulus(3'b111, 1'b0, 1'b1);
    checkOutput("post_reset_rx_out", 32'(rx_out), 32'h7);
    checkOutput("post_reset_break_det", 32'(break_det), 32'h0);
    checkOutput("post_reset_glitch_cnt", 32'(glitch_cnt), 32'h0);
    applyFor(3'b111, 5);

    // 2. Clean falling edge on ch0
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b110, 1'b0, 1'b1);
      lat++;
      if (rx_out[0] == 1'b0) break;
    end
    checkOutput("clean_edge_latency", 32'(lat), 32'd6);
    checkOutput("clean_edge_gcnt0", 32'(glitch_cnt[3:0]), 32'd0);
    applyFor(3'b111, 12);
    checkOutput("clean_rise_rx0", 32'(rx_out[0]), 32'd1);
    checkOutput("clean_rise_gcnt0", 32'(glitch_cnt[3:0]), 32'd0);

    // 3. Glitches of 1, 2 and 3 cycles on ch1
    seenLow = '0;
    for (int w = 1; w <= 3; w++) begin
      applyFor(3'b101, w);
      applyFor(3'b111, 10);
    end
    checkOutput("glitch_rx1_never_low", 32'(seenLow[1]), 32'd0);
    checkOutput("glitch_gcnt1", 32'(glitch_cnt[7:4]), 32'd3);

    // 4. Saturation on ch2, then clear coincident with an increment
    for (int i = 0; i < 20; i++) begin
      applyFor(3'b011, 1);
      applyFor(3'b111, 4);
    end
    checkOutput("sat_gcnt2", 32'(glitch_cnt[11:8]), 32'd15);
    applyStimulus(3'b011, 1'b0, 1'b1);
    applyStimulus(3'b111, 1'b0, 1'b1);
    applyStimulus(3'b111, 1'b0, 1'b1);
    applyStimulus(3'b111, 1'b1, 1'b1);
    applyStimulus(3'b111, 1'b0, 1'b1);
    checkOutput("clear_gcnt2", 32'(glitch_cnt[11:8]), 32'd0);
    checkOutput("clear_gcnt1", 32'(glitch_cnt[7:4]), 32'd0);

    // 5. Break on ch0: 150 cycles low, then high
    resetTracker();
    applyFor(3'b110, 150);
    applyFor(3'b111, 30);
    checkOutput("brk_rise_cycle", 32'(riseBrkTick - fallTick + 1), 32'd100);
    checkOutput("brk_fall_with_rise", 32'(fallBrkTick - fallTick), 32'd150);
    checkOutput("brk_rx_at_fall", 32'(rxAtBrkFall), 32'd1);
    checkOutput("brk_rx_before_fall", 32'(rxBeforeBrkFall), 32'(MASKED));
    checkOutput("brk_rx_at_rise", 32'(rxAtBrkRise), 32'(MASKED));

    // 6. Reset pulse at filtered-low cycle 120 with the pin still low
    resetTracker();
    for (int i = 0; i < 20 && fallTick < 0; i++) applyStimulus(3'b110, 1'b0, 1'b1);
    guard = 0;
    while ((tickNo - fallTick + 1) < 120 && guard < 200) begin
      applyStimulus(3'b110, 1'b0, 1'b1);
      guard++;
    end
    checkOutput("midbrk_pre_break", 32'(break_det[0]), 32'd1);
    applyStimulus(3'b110, 1'b0, 1'b0);
    checkOutput("midbrk_break_cleared", 32'(break_det[0]), 32'd0);
    checkOutput("midbrk_rx_high", 32'(rx_out[0]), 32'd1);
    resetTracker();
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b110, 1'b0, 1'b1);
      lat++;
      if (rx_out[0] == 1'b0) break;
    end
    checkOutput("midbrk_refall_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 150 && riseBrkTick < 0; i++) applyStimulus(3'b110, 1'b0, 1'b1);
    checkOutput("midbrk_rebreak_cycle", 32'(riseBrkTick - fallTick + 1), 32'd100);
    applyFor(3'b111, 20);

    @(negedge clk);
    #1;
    checkOutput("sb_drained", 32'(scoreboard.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
